// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding, parity modes and default bit timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int CLKS_PER_BIT_9600 = 1250;

    // XOR of the data bits, inverted for odd parity.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Restartable bit-period counter: one-cycle tick on the last clock of each bit,
// phase-aligned to the most recent restart. Held at zero while disabled.
module baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    input  logic i_en,
    output logic o_tick
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else if (i_restart || !i_en) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign o_tick = i_en && !i_restart && (count_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start + 8 data bits (LSB first) + optional parity + stop bits,
// timed by baud_tick in the i_clk domain with a registered, glitch-free o_tx.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = PAR_NONE
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic LAST_STOP = (STOP_BITS > 1);

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        stop_idx_q, stop_idx_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic        accept;
    logic        bit_end;

    assign accept = (state_q == ST_IDLE) && i_valid;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (accept),
        .i_en      (state_q != ST_IDLE),
        .o_tick    (bit_end)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d    = ST_START;
                    shift_d    = i_data;
                    par_d      = parity_bit(i_data, PARITY);
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the state being entered so o_tx changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_tx    = tx_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule
